position_tracker: RTL
=====================

// Module: position_tracker
// PURPOSE
//  Drives the position interface of the visited-position lookup table.
//  Decodes the ASCII move stream (^ v < >), maintains the current grid coordinate,
//  and emits one pos_change pulse per position, start position included.
//  Sits between the byte-stream input and the visited-position table.
// PARAMETERS
//  POSITION_WIDTH  8  bits per coordinate; the grid is 2**W x 2**W, unsigned
// PORTS
//  clk         in   1  clock
//  reset       in   1  reset, synchronous, active-high
//  in_valid    in   1  in_data valid this cycle
//  in_data     in   8  ASCII byte
//  in_ready    out  1  byte accepted when in_valid && in_ready
//  pos_change  out  1  one-cycle pulse: pos_x/pos_y hold a new position
//  pos_x       out  W  current x coordinate
//  pos_y       out  W  current y coordinate
//  move_count  out  32 accepted direction bytes (saturating)
//  done        out  1  end of stream reached; sticky until reset
// BEHAVIOUR
//  Reset values: pos_change=0, in_ready=0, done=0, move_count=0, pos_x=pos_y=2**(W-1).
//  FSM: INIT -> RUN -> DONE. Reset from any state returns to INIT on the next clock.
//   INIT: one cycle; pos_change=1 with the start position; in_ready=0; then RUN.
//   RUN : in_ready=1. Accepted bytes, with registered outputs one cycle after acceptance:
//     '^'(0x5E): y+1, pulse | 'v'(0x76): y-1, pulse
//     '>'(0x3E): x+1, pulse | '<'(0x3C): x-1, pulse
//     0x0A: go to DONE, done=1 next cycle, no pulse
//     any other byte: ignored, no pulse, no count
//   DONE: in_ready=0; pos_change=0; outputs frozen.
//  Arithmetic: modulo 2**W. 0-1 wraps to 2**W-1; 2**W-1 plus 1 wraps to 0.
//   No wrap flag. The input set is sized so wraps do not occur.
//  Throughput: one byte per cycle. Back-to-back moves give back-to-back pulses.
//  pos_x and pos_y change only on cycles where pos_change=1.
//  move_count: +1 per direction byte. Saturates at 2**32-1.
//  in_valid while in_ready=0: ignored. The sender holds the byte.
//  Reset asserted mid-stream: the pulse for that cycle is dropped. Reset values appear next cycle.
// CONFIGURATION
//  ROBO_SANTA_EN defined: two walkers, A and B, each with its own x/y register.
//   Both start at the centre. Direction bytes alternate A,B,A,... starting with A.
//   Ignored bytes do not advance the alternation.
//   pos_x/pos_y show the walker that just moved.
//   INIT emits one start pulse only, because the shared start position counts once.
//  Undefined: single walker as above. No B register and no alternation state is synthesised.
// TESTING
//  1. Reset release, in_valid=0 -> exactly one pulse at (128,128) in the first cycle after reset, then silence.
//  2. Stream ">", "\n" -> pulse at (129,128); done=1 the cycle after "\n"; move_count=1.
//  3. Back-to-back "^v^v^v^v^v" -> 10 consecutive pulses alternating (128,129)/(128,128); move_count=10.
//  4. W=2, "<<<" from (2,2) -> x sequence 1, 0, 3 (wrap); y=2 throughout.
//  5. "a^ x>" with junk bytes -> 2 pulses only; move_count=2; junk adds no cycles of latency.
//  6. Reset asserted after 3 moves of "^^^^^" -> outputs back to centre; INIT pulse again; move_count=0.
//  ROBO_SANTA_EN: "^v" -> (128,129) then (128,127); "^>v<" -> A ends (128,128), B ends (128,128).

Source files
------------

// File: rtl/position_tracker.sv
// position_tracker: decodes an ASCII move stream into grid positions, one pulse per new position.
// Define ROBO_SANTA_EN for two alternating walkers sharing the output position bus.
module position_tracker #(
  parameter int POSITION_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  output logic                      in_ready,
  output logic                      pos_change,
  output logic [POSITION_WIDTH-1:0] pos_x,
  output logic [POSITION_WIDTH-1:0] pos_y,
  output logic [31:0]               move_count,
  output logic                      done
);
  localparam int W = POSITION_WIDTH;
  localparam logic [W-1:0] CENTRE = {1'b1, {(W-1){1'b0}}};
  typedef enum logic [1:0] {INIT, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic acc, up, dn, rt, lf, move, eol;
  logic [W-1:0] cur_x, cur_y, nx, ny;
  assign in_ready = state == RUN;
  assign acc  = in_ready && in_valid;
  assign up   = in_data == 8'h5E;
  assign dn   = in_data == 8'h76;
  assign rt   = in_data == 8'h3E;
  assign lf   = in_data == 8'h3C;
  assign move = acc && (up || dn || rt || lf);
  assign eol  = acc && in_data == 8'h0A;
`ifdef ROBO_SANTA_EN
  logic [W-1:0] a_x, a_y, b_x, b_y;
  logic turn;
  assign cur_x = turn ? b_x : a_x;
  assign cur_y = turn ? b_y : a_y;
`else
  assign cur_x = pos_x;
  assign cur_y = pos_y;
`endif
  always_comb begin
    nx = rt ? cur_x + W'(1) : lf ? cur_x - W'(1) : cur_x;
    ny = up ? cur_y + W'(1) : dn ? cur_y - W'(1) : cur_y;
    state_nxt = state == INIT ? RUN : eol ? DONE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= INIT;
      pos_change <= 1'b0;
      done       <= 1'b0;
      move_count <= '0;
      pos_x      <= CENTRE;
      pos_y      <= CENTRE;
`ifdef ROBO_SANTA_EN
      a_x  <= CENTRE;
      a_y  <= CENTRE;
      b_x  <= CENTRE;
      b_y  <= CENTRE;
      turn <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      pos_change <= state == INIT || move;
      done       <= done || eol;
      if (move) begin
        pos_x <= nx;
        pos_y <= ny;
        if (move_count != '1) move_count <= move_count + 32'd1;
`ifdef ROBO_SANTA_EN
        turn <= ~turn;
        if (turn) begin
          b_x <= nx;
          b_y <= ny;
        end else begin
          a_x <= nx;
          a_y <= ny;
        end
`endif
      end
    end
  end
endmodule
